// File: rtl/lightstand_pkg.sv
// Shared types and select codes for the light-stand brightness controller.
package lightstand_pkg;

   localparam int NUM_LEVELS = 4;
   localparam int NUM_BTN    = 2;
   localparam int BTN_UP     = 0;
   localparam int BTN_OFF    = 1;

   localparam logic [2:0] SEL_OFF = 3'b000;
   localparam logic [2:0] SEL_L1  = 3'b001;
   localparam logic [2:0] SEL_L2  = 3'b010;
   localparam logic [2:0] SEL_L3  = 3'b011;
   localparam logic [2:0] SEL_L4  = 3'b100;

   typedef enum logic [2:0] {
      S_OFF = 3'd0,
      S_L1  = 3'd1,
      S_L2  = 3'd2,
      S_L3  = 3'd3,
      S_L4  = 3'd4
   } state_t;

   function automatic logic [2:0] state_sel(input state_t s);
      logic [2:0] sel;
      sel = SEL_OFF;
      case (s)
         S_L1:    sel = SEL_L1;
         S_L2:    sel = SEL_L2;
         S_L3:    sel = SEL_L3;
         S_L4:    sel = SEL_L4;
         default: sel = SEL_OFF;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchronizer -> counting debouncer -> one-cycle press pulse.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_raw,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync;
   logic             level;
   logic             level_q;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync    <= '0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         sync    <= {sync[0], btn_raw};
         level_q <= level;
         // Any cycle agreeing with the accepted level restarts the stability window.
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            level <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Combinational pulse keeps press-to-state latency at DEBOUNCE_CYCLES+3.
   assign press = level & ~level_q;

endmodule

// File: rtl/lightstand_mode_fsm.sv
// Light-stand mode controller: debounced up/off buttons step OFF->L1..L4 and drive the PWM mux select.
// Optional idle auto-off is enabled by defining LIGHTSTAND_AUTO_OFF_EN.
module lightstand_mode_fsm
   import lightstand_pkg::*;
#(
   parameter int unsigned     DEBOUNCE_CYCLES = 1_000_000,
   parameter longint unsigned AUTO_OFF_CYCLES = 64'd6_000_000_000
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_btn_up,
   input  logic       i_btn_off,
   output logic [2:0] o_sel,
   output logic       o_on,
   output logic       o_change
);

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] press;
   logic               timeout;
   state_t             state;
   state_t             state_nxt;

   assign btn_raw[BTN_UP]  = i_btn_up;
   assign btn_raw[BTN_OFF] = i_btn_off;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk    (i_clk),
         .reset_n(i_reset_n),
         .btn_raw(btn_raw[g]),
         .press  (press[g])
      );
   end

`ifdef LIGHTSTAND_AUTO_OFF_EN
   localparam int IDLE_W = $clog2(AUTO_OFF_CYCLES);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(AUTO_OFF_CYCLES - 1);

   logic [IDLE_W-1:0] idle_cnt;

   assign timeout = (state != S_OFF) && (idle_cnt == IDLE_MAX);

   // Sitting in or entering OFF also clears, so the count always starts from the last press.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n || press[BTN_UP] || press[BTN_OFF] || state_nxt == S_OFF)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + IDLE_W'(1);
   end
`else
   logic unused_auto_off;
   assign unused_auto_off = ^AUTO_OFF_CYCLES;
   assign timeout         = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      if (press[BTN_OFF]) begin
         state_nxt = S_OFF;
      end else if (press[BTN_UP]) begin
         if (state == state_t'(NUM_LEVELS))
            state_nxt = S_OFF;
         else
            state_nxt = state_t'(state + 3'd1);
      end else if (timeout) begin
         state_nxt = S_OFF;
      end
   end

   // Outputs are registered from the next state so they move on the same edge as the state.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state    <= S_OFF;
         o_sel    <= SEL_OFF;
         o_on     <= 1'b0;
         o_change <= 1'b0;
      end else begin
         state    <= state_nxt;
         o_sel    <= state_sel(state_nxt);
         o_on     <= (state_nxt != S_OFF);
         o_change <= (state_nxt != state);
      end
   end

endmodule

// File: tb/tb_lightstand_mode_fsm.sv
// Scoreboard bench: a window-based button model predicts every level change and its cycle.
module tb_lightstand_mode_fsm;

   localparam int D = 4;
   localparam int N = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       up = 1'b0;
   logic       off = 1'b0;
   logic [2:0] o_sel;
   logic       o_on;
   logic       o_change;

   always #5 clk = ~clk;

   lightstand_mode_fsm #(
      .DEBOUNCE_CYCLES(D),
      .AUTO_OFF_CYCLES(N)
   ) dut (
      .i_clk    (clk),
      .i_reset_n(rst_n),
      .i_btn_up (up),
      .i_btn_off(off),
      .o_sel    (o_sel),
      .o_on     (o_on),
      .o_change (o_change)
   );

   typedef struct {
      int sel;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   lvl = 0;
   int   t_p = 0;
   bit   chk = 1'b0;
   bit [D+1:0] h_up = '0;
   bit [D+1:0] h_off = '0;
   bit   deb_up = 1'b0, deb_off = 1'b0;
   bit   pend_up = 1'b0, pend_off = 1'b0;

   // Level is accepted once the last D synchronized samples all disagree with it.
   function automatic bit flips(input bit [D+1:0] h, input bit deb);
      return h[D+1:2] == {D{~deb}};
   endfunction

   always @(posedge clk) begin
      int nl;
      cyc++;
      if (!rst_n) begin
         h_up = '0; h_off = '0;
         deb_up = 0; deb_off = 0;
         pend_up = 0; pend_off = 0;
         lvl = 0;
         sb.delete();
      end else begin
         nl = lvl;
         if (pend_off) nl = 0;
         else if (pend_up) nl = (lvl + 1) % 5;
`ifdef LIGHTSTAND_AUTO_OFF_EN
         else if (lvl != 0 && cyc - t_p == N) nl = 0;
`endif
         if (pend_up || pend_off) t_p = cyc;
         if (nl != lvl) sb.push_back('{nl, cyc});
         lvl = nl;
         h_up  = {h_up[D:0], up};
         h_off = {h_off[D:0], off};
         pend_up = 0; pend_off = 0;
         if (flips(h_up, deb_up)) begin deb_up = ~deb_up; pend_up = deb_up; end
         if (flips(h_off, deb_off)) begin deb_off = ~deb_off; pend_off = deb_off; end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (chk) begin
         if (o_change) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL change_unexpected cyc=%0d sel got=%0d want no change", cyc, o_sel);
            end else begin
               e = sb.pop_front();
               if (o_sel != 3'(e.sel) || o_on != (e.sel != 0) || cyc != e.cyc) begin
                  miscompares++;
                  $display("FAIL change_event sel got=%0d want=%0d on got=%0d cyc got=%0d want=%0d",
                           o_sel, e.sel, o_on, cyc, e.cyc);
               end
            end
         end
         vectors++;
         if (o_sel != 3'(lvl) || o_on != (lvl != 0)) begin
            miscompares++;
            $display("FAIL steady_level cyc=%0d sel got=%0d want=%0d on got=%0d", cyc, o_sel, lvl, o_on);
         end
      end
   end

   task automatic press(input bit u, input bit o, input int hold, input int rel);
      up = u; off = o;
      repeat (hold) @(negedge clk);
      up = 0; off = 0;
      repeat (rel) @(negedge clk);
   endtask

   task automatic expect_sel(input string name, input int want);
      vectors++;
      if (o_sel != 3'(want)) begin
         miscompares++;
         $display("FAIL %s sel got=%0d want=%0d", name, o_sel, want);
      end
   endtask

   initial begin
      int len;
      repeat (3) @(negedge clk);
      vectors++;
      if (o_sel != 3'd0 || o_on != 1'b0 || o_change != 1'b0) begin
         miscompares++;
         $display("FAIL reset_state sel=%0d on=%0d change=%0d want 0 0 0", o_sel, o_on, o_change);
      end
      rst_n = 1; chk = 1;
      repeat (20) @(negedge clk);
      expect_sel("idle_after_reset", 0);

      for (int i = 0; i < 5; i++) press(1, 0, 10, 10);
      expect_sel("five_ups_wrap", 0);

      up = 1; repeat (2) @(negedge clk);
      up = 0; @(negedge clk);
      up = 1; repeat (2) @(negedge clk);
      up = 0; repeat (10) @(negedge clk);
      expect_sel("bounce_ignored", 0);
      press(1, 0, 40, 10);
      expect_sel("long_hold_one_step", 1);

      press(0, 1, 6, 6);
      for (int i = 0; i < 3; i++) press(1, 0, 6, 6);
      expect_sel("reach_l3", 3);
      press(1, 1, 6, 6);
      expect_sel("up_off_same_cycle", 0);
      press(0, 1, 6, 6);
      expect_sel("off_in_off", 0);

      for (int i = 0; i < 4; i++) press(1, 0, 6, 6);
      expect_sel("reach_l4", 4);
      up = 1; repeat (2) @(negedge clk);
      rst_n = 0; @(negedge clk);
      rst_n = 1; up = 0;
      repeat (10) @(negedge clk);
      expect_sel("reset_mid_debounce", 0);
      press(1, 0, 6, 2);
      expect_sel("fresh_press", 1);
      repeat (200) @(negedge clk);
`ifdef LIGHTSTAND_AUTO_OFF_EN
      expect_sel("idle_auto_off", 0);
`else
      expect_sel("idle_hold", 1);
`endif

      repeat (300) begin
         if ($urandom_range(0, 99) < 3) begin
            rst_n = 0; @(negedge clk); rst_n = 1;
         end else begin
            up  = 1'($urandom_range(0, 1));
            off = ($urandom_range(0, 5) == 0);
            len = $urandom_range(1, 12);
            repeat (len) @(negedge clk);
         end
      end
      up = 0; off = 0;
      repeat (60) @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL missing_changes pending got=%0d want=0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lightstand_mode_fsm.md
# lightstand_mode_fsm

Brightness-mode controller for the light stand. Debounces two push buttons, steps a five-state mode machine (OFF, L1–L4), and drives the 3-bit select of the 4:1 PWM mux. Select code 000 forces the lamp dark; codes 001–100 choose one of four PWM duty-cycle taps. The block sits between the board buttons and the mux select input.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000 — consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); must be ≥ 2.
- AUTO_OFF_CYCLES, 6_000_000_000 — idle cycles before automatic return to OFF; used only with LIGHTSTAND_AUTO_OFF_EN.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_btn_up  in  1  raw, asynchronous "next level" button, active high.
- i_btn_off  in  1  raw, asynchronous "force off" button, active high.
- o_sel  out  3  mux select: 000 OFF, 001 L1, 010 L2, 011 L3, 100 L4; codes 101–111 are never driven.
- o_on  out  1  high whenever the state is not OFF.
- o_change  out  1  one-cycle pulse, asserted in the same cycle o_sel takes a new value.

## Operation
- Each button path has a 2-flop synchronizer, then a debouncer, then a rising-edge detector.
- Debouncer:
  - Its counter clears whenever the synced level equals the debounced level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the debounced level takes the synced level and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are discarded.
- Edge detector: emits a one-cycle press pulse when the debounced level goes 0→1. A button release produces no pulse.
- State machine: S_OFF, S_L1, S_L2, S_L3, S_L4. o_sel is a direct registered encoding of the state.
  - Up pulse: S_OFF→S_L1→S_L2→S_L3→S_L4→S_OFF (wraps at L4).
  - Off pulse: any state → S_OFF.
  - Up and off pulses in the same cycle: off wins.
  - Off pulse while already in S_OFF: no change, no o_change pulse.
  - Holding a button down produces exactly one step; there is no auto-repeat.
- Reset (i_reset_n low at a clock edge): state S_OFF, o_sel=000, o_on=0, o_change=0.
  - Synchronizers, debounced levels, counters and edge registers all clear to 0.
  - A button already held during reset is accepted as a new press after release of reset plus the debounce time.
  - Reset asserted mid-debounce discards the partial count.

## Timing
- A raw press held stable reaches o_sel/o_change DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it high:
  - 2 synchronizer edges
  - DEBOUNCE_CYCLES edges to accept the level
  - 1 edge to register the state.
- All outputs are registered; there is no combinational path from inputs to outputs.
- o_on and o_sel update on the same edge.

## Configuration
- LIGHTSTAND_AUTO_OFF_EN defined:
  - Adds an idle counter of width $clog2(AUTO_OFF_CYCLES).
  - The counter runs while the state ≠ S_OFF and clears on every accepted press and on entry to S_OFF.
  - When it reaches AUTO_OFF_CYCLES-1, the state goes to S_OFF with a single o_change pulse.
  - A press arriving in the same cycle as the timeout takes priority: an up press is applied normally and the counter clears.
- Macro undefined: no idle counter; the state holds indefinitely; AUTO_OFF_CYCLES is ignored.

## Structure
- Shared package lightstand_pkg holds:
  - the state enumeration
  - the select code constants SEL_OFF, SEL_L1–SEL_L4 (3-bit)
  - the number of levels (4).
- Sub-module btn_debounce, parameterized by DEBOUNCE_CYCLES, contains synchronizer, debouncer and rising-edge pulse. It is instantiated twice.
- The top level holds the state register, the output registers and the optional idle counter.

## Test plan
Bench settings: DEBOUNCE_CYCLES=4, AUTO_OFF_CYCLES=50, LIGHTSTAND_AUTO_OFF_EN both defined and undefined.
- Reset, then idle 20 cycles → o_sel=000, o_on=0, o_change never pulses.
- Five clean up presses (each held 10 cycles, released 10) → o_sel sequence 001, 010, 011, 100, 000. Each step lands 7 edges after the press edge with a single o_change pulse.
- Up bounce (high 2, low 1, high 2, low) → no change. Up held 40 cycles → exactly one step.
- From L3, up and off pressed in the same cycle → o_sel=000. Off press while in OFF → no o_change.
- Reset asserted for 1 cycle while in L4 and mid-debounce of an up press → o_sel=000. The partial press is discarded; a fresh press gives 001.
- Macro defined: enter L1 and idle → o_sel=000 exactly 50 cycles after the last accepted press, with one o_change. Macro undefined: still 001 after 200 cycles.
